instr_fetch_mem: RTL
====================

# instr_fetch_mem

Parametrised instruction memory with a valid/ready fetch port, a word-load port for program preload, configurable read latency, response buffering with back-pressure, flush and fault reporting. Sits between the PC/fetch stage and decode; it replaces the fixed 64-byte, reset-initialised instruction store. Program contents are written through the load port, not hard-coded at reset.

## Interface
- DEPTH_WORDS, 256, number of 32-bit instruction words (power of two, 16..4096)
- READ_LATENCY, 1, cycles from fetch acceptance to response availability (1..4)
- RESP_DEPTH, READ_LATENCY+1, total outstanding capacity (pipeline plus response buffer)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; clock is the only clock
- load_en  input  1  write one word this cycle
- load_addr  input  32  byte address of word (bits [1:0] ignored)
- load_data  input  32  instruction word, little-endian byte order in memory
- load_be  input  4  byte enables for load_data
- flush  input  1  discard all in-flight and buffered fetches
- req_valid  input  1  fetch request present
- req_ready  output  1  request accepted when req_valid && req_ready at rising edge
- req_pc  input  32  fetch byte address
- resp_valid  output  1  response at buffer head
- resp_ready  input  1  consumer takes response when resp_valid && resp_ready
- resp_instr  output  32  instruction word
- resp_pc  output  32  PC of that response
- resp_fault  output  2  00 ok, 01 misaligned (req_pc[1:0]≠0), 10 out of range (req_pc[31:2] ≥ DEPTH_WORDS)

## Operation
- Memory: DEPTH_WORDS × 32; not cleared by reset; contents persist across reset.
- Load: at rising edge with load_en, bytes with load_be set are written at word index load_addr[ADDR_W+1:2]; out-of-range load_addr silently dropped.
- Load priority: req_ready = 0 whenever load_en or flush is high.
- req_ready = reset deasserted && !load_en && !flush && (occupancy < RESP_DEPTH); occupancy = in-flight + buffered entries.
- Memory read occurs at the acceptance edge; a later load to the same word does not alter an in-flight response.
- Fault precedence: misaligned over out-of-range; faulting responses carry resp_instr = 32'h00000013 (NOP) and flow through the same pipeline/order.
- Responses returned strictly in request order; pipeline of READ_LATENCY stages (valid, pc, word, fault) feeds a FIFO of RESP_DEPTH entries; FIFO head drives resp_*.
- Occupancy counter: +1 on acceptance, −1 on response handshake, net 0 on both in one cycle; never exceeds RESP_DEPTH.
- Flush: at the edge with flush high, all pipeline valids and FIFO entries cleared, occupancy = 0; any response handshake in that cycle still counts as consumed; no acceptance in that cycle.

## Timing
- Reset (reset low, async): req_ready=0, resp_valid=0, resp_instr=0, resp_pc=0, resp_fault=00, occupancy=0, pipeline valids=0. req_ready rises one cycle after reset deasserts.
- Latency: request accepted at edge k → resp_valid high in the cycle after edge k+READ_LATENCY−1 (READ_LATENCY=1: next cycle).
- Throughput: one fetch per cycle sustained with resp_ready held high.
- Back-pressure: with resp_ready low, exactly RESP_DEPTH requests are accepted, then req_ready stays low until a response is consumed; req_ready rises the cycle after that handshake.
- resp_* stable while resp_valid && !resp_ready.
- FIFO pointers wrap modulo RESP_DEPTH; simultaneous push and pop at full or empty handled without loss or duplication.
- Reset mid-operation: all in-flight/buffered fetches lost; memory retained.

## Test plan
- Load 0x00940333 at 0x0 and 0x413903B3 at 0x4; fetch 0x0, 0x4 back-to-back with READ_LATENCY=1 → responses in consecutive cycles, fault 00, correct resp_pc.
- READ_LATENCY=3, resp_ready low, stream fetches → exactly 4 accepted, req_ready low; then resp_ready high → 4 in-order responses, req_ready reasserts next cycle.
- Fetch 0x2 and 0x400 (DEPTH_WORDS=256) → resp_fault 01 and 10, resp_instr 0x00000013.
- Load with load_be=4'b0011, data 0xFFFF1234 over existing 0xAABBCCDD → fetch returns 0xAABB1234; req_ready low during load cycle.
- Two fetches in flight, assert flush one cycle → no responses emerge, occupancy 0, next fetch returns correct data after READ_LATENCY.
- Assert reset low with full buffer → resp_valid and req_ready drop immediately; after release, previously loaded words fetch correctly.

Source files
------------

// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus of the instruction memory: program load port, flush,
// fetch request channel and response channel.
interface instr_fetch_mem_if;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [3:0]  load_be;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic [1:0]  resp_fault;

    modport master (
        output load_en, load_addr, load_data, load_be, flush,
        output req_valid, req_pc, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_pc, resp_fault
    );

    modport slave (
        input  load_en, load_addr, load_data, load_be, flush,
        input  req_valid, req_pc, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_pc, resp_fault
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Instruction memory between fetch and decode. Words are preloaded through
// the load port; fetches travel through a READ_LATENCY-deep path into an
// in-order response FIFO. Occupancy (in flight + buffered) never exceeds
// RESP_DEPTH, so the FIFO can never overflow.
module instr_fetch_mem #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
    input logic              clock,
    input logic              reset,
    instr_fetch_mem_if.slave bus
);
    localparam int          ADDR_W = $clog2(DEPTH_WORDS);
    localparam int          PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int          CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [1:0]  FAULT_OK       = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
    localparam logic [1:0]  FAULT_RANGE    = 2'b10;

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic             r_rst_done;
    logic [CNT_W-1:0] r_occ;

    logic [31:0]      r_fifo_pc    [RESP_DEPTH];
    logic [31:0]      r_fifo_instr [RESP_DEPTH];
    logic [1:0]       r_fifo_fault [RESP_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_fcount;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_resp_valid;
    logic              w_pop;
    logic              w_load_in_range;
    logic [ADDR_W-1:0] w_load_idx;
    logic [1:0]        w_req_fault;
    logic [31:0]       w_req_instr;
    logic              w_push_valid;
    logic [31:0]       w_push_pc;
    logic [31:0]       w_push_instr;
    logic [1:0]        w_push_fault;
    logic              w_unused_load_lsb;

    // Byte offset of a load is meaningless: loads are always whole-word slots.
    assign w_unused_load_lsb = ^bus.load_addr[1:0];

    assign w_load_in_range = (bus.load_addr[31:ADDR_W+2] == '0);
    assign w_load_idx      = bus.load_addr[ADDR_W+1:2];

    // A load or flush owns the cycle, so a fetch never races a write.
    assign w_req_ready  = r_rst_done && !bus.load_en && !bus.flush
                          && (r_occ < CNT_W'(RESP_DEPTH));
    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_resp_valid = (r_fcount != '0);
    assign w_pop        = w_resp_valid && bus.resp_ready;

    // Misalignment is reported ahead of out-of-range; faults carry a NOP.
    always_comb begin
        w_req_fault = FAULT_OK;
        if (bus.req_pc[1:0] != 2'b00) begin
            w_req_fault = FAULT_MISALIGN;
        end else if (bus.req_pc[31:ADDR_W+2] != '0) begin
            w_req_fault = FAULT_RANGE;
        end
    end

    assign w_req_instr = (w_req_fault == FAULT_OK) ? r_mem[bus.req_pc[ADDR_W+1:2]] : NOP;

    // Byte-masked program load; memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (bus.load_en && w_load_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.load_be[b]) begin
                    r_mem[w_load_idx][8*b +: 8] <= bus.load_data[8*b +: 8];
                end
            end
        end
    end

    // Holds req_ready low for the first cycle after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // The word is captured at the acceptance edge; with latency 1 it goes
    // straight into the FIFO, otherwise through READ_LATENCY-1 registers.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign w_push_valid = w_accept;
            assign w_push_pc    = bus.req_pc;
            assign w_push_instr = w_req_instr;
            assign w_push_fault = w_req_fault;
        end else begin : g_pipe
            localparam int STAGES = READ_LATENCY - 1;
            logic        r_pv     [STAGES];
            logic [31:0] r_ppc    [STAGES];
            logic [31:0] r_pinstr [STAGES];
            logic [1:0]  r_pfault [STAGES];

            // Stage valids shift each cycle; a flush drops everything in flight.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < STAGES; i++) r_pv[i] <= 1'b0;
                end else if (bus.flush) begin
                    for (int i = 0; i < STAGES; i++) r_pv[i] <= 1'b0;
                end else begin
                    r_pv[0] <= w_accept;
                    for (int i = 1; i < STAGES; i++) r_pv[i] <= r_pv[i-1];
                end
            end

            // Payload shifts alongside; it is only meaningful where the valid is set.
            always_ff @(posedge clock) begin
                r_ppc[0]    <= bus.req_pc;
                r_pinstr[0] <= w_req_instr;
                r_pfault[0] <= w_req_fault;
                for (int i = 1; i < STAGES; i++) begin
                    r_ppc[i]    <= r_ppc[i-1];
                    r_pinstr[i] <= r_pinstr[i-1];
                    r_pfault[i] <= r_pfault[i-1];
                end
            end

            assign w_push_valid = r_pv[STAGES-1] && !bus.flush;
            assign w_push_pc    = r_ppc[STAGES-1];
            assign w_push_instr = r_pinstr[STAGES-1];
            assign w_push_fault = r_pfault[STAGES-1];
        end
    endgenerate

    // Outstanding count; a flush zeroes it even if a pop happens that cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    // Response FIFO control; pointers wrap at RESP_DEPTH, which need not be a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
        end else if (bus.flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
        end else begin
            if (w_push_valid) begin
                r_wptr <= (r_wptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            r_fcount <= r_fcount + CNT_W'(w_push_valid) - CNT_W'(w_pop);
        end
    end

    // FIFO storage; entries are qualified by the count so no reset is needed.
    always_ff @(posedge clock) begin
        if (w_push_valid) begin
            r_fifo_pc[r_wptr]    <= w_push_pc;
            r_fifo_instr[r_wptr] <= w_push_instr;
            r_fifo_fault[r_wptr] <= w_push_fault;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_instr = w_resp_valid ? r_fifo_instr[r_rptr] : '0;
    assign bus.resp_pc    = w_resp_valid ? r_fifo_pc[r_rptr]    : '0;
    assign bus.resp_fault = w_resp_valid ? r_fifo_fault[r_rptr] : 2'b00;
endmodule
